// File: rtl/posterior_state_serial.sv
// -----------------------------------------------------------------------------
// posterior_state_serial
//   Kalman measurement-update (correction) step for a 2-state, 1-measurement
//   filter:  y = z - H*x_prior ;  x_post = x_prior + K*y
//   The datapath is serial and resource-shared. It uses two fixed-point
//   multipliers, one add/sub unit and a small FSM sequencing
//   IDLE -> HX -> INN -> GAIN -> UPD0 -> UPD1 -> IDLE.
//   Every N-bit word is signed Q(N-FRAC).FRAC. Each product is carried at full
//   2N width with 2*FRAC fractional bits. Each narrowing to N bits takes bits
//   [FRAC+N-1:FRAC], which floors toward -inf and wraps on overflow.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start           : operation request, sampled only in IDLE
//   xp00, xp10      : prior state vector
//   h00, h01        : measurement row
//   z               : scalar measurement
//   k00, k10        : Kalman gain column
//   busy            : high from the cycle after start is accepted until done
//   done            : one-cycle pulse, results valid
//   X_POST00/10     : posterior state
//   INNOV           : innovation y
// -----------------------------------------------------------------------------
module posterior_state_serial #(
    parameter int N    = 20,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] xp00,
    input  logic [N-1:0] xp10,
    input  logic [N-1:0] h00,
    input  logic [N-1:0] h01,
    input  logic [N-1:0] z,
    input  logic [N-1:0] k00,
    input  logic [N-1:0] k10,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] X_POST00,
    output logic [N-1:0] X_POST10,
    output logic [N-1:0] INNOV
);

    localparam int W = 2 * N;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HX   = 3'd1,
        S_INN  = 3'd2,
        S_GAIN = 3'd3,
        S_UPD0 = 3'd4,
        S_UPD1 = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    // Operand latches (captured on accept so inputs may change afterwards)
    logic [N-1:0] xp00_q, xp10_q, z_q, k00_q, k10_q;
    // Multiplier operand registers
    logic [N-1:0] ma0_q, mb0_q, ma1_q, mb1_q;
    // Intermediates
    logic [W-1:0] hx_q, g0_q, g1_q;
    logic [N-1:0] y_q;
    logic [N-1:0] xpost00_q, xpost10_q, innov_q;

    // Sign-extend an N-bit word to 2N and align it to 2*FRAC fractional bits.
    function automatic logic [W-1:0] align(input logic [N-1:0] v);
        return {{(N-FRAC){v[N-1]}}, v, {FRAC{1'b0}}};
    endfunction

    function automatic logic [W-1:0] sext(input logic [N-1:0] v);
        return {{N{v[N-1]}}, v};
    endfunction

    // ---------------- multipliers (full 2N signed products) -----------------
    logic signed [W-1:0] p0, p1;
    assign p0 = $signed(sext(ma0_q)) * $signed(sext(mb0_q));
    assign p1 = $signed(sext(ma1_q)) * $signed(sext(mb1_q));

    // ---------------- shared add/sub unit -----------------------------------
    // Subtraction reuses the adder as A + ~B + 1.
    logic [W-1:0] add_a, add_b, add_bx;
    logic         add_sub;
    logic [W:0]   add_sum;
    logic [N-1:0] add_n;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        unique case (state_q)
            S_HX:   begin add_a = p0;              add_b = p1;   end
            S_INN:  begin add_a = align(z_q);      add_b = hx_q; add_sub = 1'b1; end
            S_UPD0: begin add_a = align(xp00_q);   add_b = g0_q; end
            S_UPD1: begin add_a = align(xp10_q);   add_b = g1_q; end
            default: ;
        endcase
    end

    assign add_bx  = add_b ^ {W{add_sub}};
    assign add_sum = {add_a[W-1], add_a} + {add_bx[W-1], add_bx} + {{W{1'b0}}, add_sub};
    assign add_n   = add_sum[FRAC+N-1:FRAC];

    // ---------------- FSM --------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_HX;
                busy_d  = 1'b1;
            end
            S_HX:   state_d = S_INN;
            S_INN:  state_d = S_GAIN;
            S_GAIN: state_d = S_UPD0;
            S_UPD0: state_d = S_UPD1;
            S_UPD1: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xp00_q    <= '0;
            xp10_q    <= '0;
            z_q       <= '0;
            k00_q     <= '0;
            k10_q     <= '0;
            ma0_q     <= '0;
            mb0_q     <= '0;
            ma1_q     <= '0;
            mb1_q     <= '0;
            hx_q      <= '0;
            g0_q      <= '0;
            g1_q      <= '0;
            y_q       <= '0;
            xpost00_q <= '0;
            xpost10_q <= '0;
            innov_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    xp00_q <= xp00;
                    xp10_q <= xp10;
                    z_q    <= z;
                    k00_q  <= k00;
                    k10_q  <= k10;
                    ma0_q  <= h00;
                    mb0_q  <= xp00;
                    ma1_q  <= h01;
                    mb1_q  <= xp10;
                end
                S_HX:   hx_q <= add_sum[W-1:0];
                S_INN: begin
                    innov_q <= add_n;
                    y_q     <= add_n;
                    ma0_q   <= k00_q;
                    mb0_q   <= add_n;
                    ma1_q   <= k10_q;
                    mb1_q   <= add_n;
                end
                S_GAIN: begin
                    g0_q <= p0;
                    g1_q <= p1;
                end
                S_UPD0: xpost00_q <= add_n;
                S_UPD1: xpost10_q <= add_n;
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign X_POST00 = xpost00_q;
    assign X_POST10 = xpost10_q;
    assign INNOV    = innov_q;

endmodule

// File: tb/tb_posterior_state_serial.sv
// -----------------------------------------------------------------------------
// tb_posterior_state_serial
//   Directed vectors with hand-computed Q10 expectations for the
//   posterior-state (correction) block. Inputs are driven on the falling edge,
//   and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_posterior_state_serial;

    localparam int N    = 20;
    localparam int FRAC = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] xp00 = '0, xp10 = '0, h00 = '0, h01 = '0, z = '0, k00 = '0, k10 = '0;
    logic         busy, done;
    logic [N-1:0] X_POST00, X_POST10, INNOV;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    posterior_state_serial #(.N(N), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .xp00     (xp00),
        .xp10     (xp10),
        .h00      (h00),
        .h01      (h01),
        .z        (z),
        .k00      (k00),
        .k10      (k10),
        .busy     (busy),
        .done     (done),
        .X_POST00 (X_POST00),
        .X_POST10 (X_POST10),
        .INNOV    (INNOV)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int s(input logic [N-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic set_in(input int a0, input int a1, input int hh0, input int hh1,
                          input int zz, input int kk0, input int kk1);
        xp00 = a0[N-1:0];  xp10 = a1[N-1:0];
        h00  = hh0[N-1:0]; h01  = hh1[N-1:0];
        z    = zz[N-1:0];
        k00  = kk0[N-1:0]; k10  = kk1[N-1:0];
    endtask

    // Run one operation and check the results and handshake timing.
    // scramble: inputs are changed right after the accepting edge.
    // poke    : a start pulse is issued while the block is busy.
    task automatic run_op(input string tag,
                          input int a0, input int a1, input int hh0, input int hh1,
                          input int zz, input int kk0, input int kk1,
                          input int e_innov, input int e_x0, input int e_x1,
                          input bit scramble, input bit poke);
        int lat, busy_cnt, extra;
        @(negedge clk);
        set_in(a0, a1, hh0, hh1, zz, kk0, kk1);
        start = 1'b1;
        @(negedge clk);                       // after E0
        start = 1'b0;
        if (scramble) set_in(777, -555, 3000, -2000, 12345, -999, 4444);
        chk({tag, "_busy_e0"}, int'(busy), 1);
        busy_cnt = int'(busy);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);                   // after Ec
            if (poke && c == 2) start = 1'b1;
            if (poke && c == 3) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            busy_cnt += int'(busy);
        end
        chk({tag, "_latency"},  lat, 5);
        chk({tag, "_busy_cyc"}, busy_cnt, 5);
        chk({tag, "_busy_done"}, int'(busy), 0);
        chk({tag, "_innov"}, s(INNOV), e_innov);
        chk({tag, "_x0"},    s(X_POST00), e_x0);
        chk({tag, "_x1"},    s(X_POST10), e_x1);
        extra = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            extra += int'(done);
        end
        chk({tag, "_no_extra_done"}, extra, 0);
        chk({tag, "_hold_x0"}, s(X_POST00), e_x0);
    endtask

    initial begin
        int pulses, first_e, second_e;

        // ---------------- reset state ----------------
        #12;
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_innov", s(INNOV), 0);
        chk("rst_x0",    s(X_POST00), 0);
        chk("rst_x1",    s(X_POST10), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed vectors ----------------
        run_op("nominal", 1024, 2048, 1024, 0, 1536, 512, 256,  512, 1280, 2176, 1'b0, 1'b0);
        run_op("neg_innov", 2048, 0, 1024, 1024, 1024, 512, 512, -1024, 1536, -512, 1'b0, 1'b0);
        run_op("zero_gain", -300, 700, 1024, 1024, 0, 0, 0, -400, -300, 700, 1'b0, 1'b0);
        run_op("floor_pos", 0, 0, 1024, 0, 1, 512, 512, 1, 0, 0, 1'b0, 1'b0);
        run_op("floor_neg", 0, 0, 1024, 0, -1, 512, 512, -1, -1, -1, 1'b0, 1'b0);
        run_op("scramble", 1024, 2048, 1024, 0, 1536, 512, 256, 512, 1280, 2176, 1'b1, 1'b0);
        run_op("poke", 2048, 0, 1024, 1024, 1024, 512, 512, -1024, 1536, -512, 1'b0, 1'b1);

        // ---------------- start held high for 10 cycles ----------------
        @(negedge clk);
        set_in(1024, 2048, 1024, 0, 1536, 512, 256);
        start = 1'b1;
        pulses = 0; first_e = -1; second_e = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);                   // after Ek
            if (k == 9) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) first_e = k;
                else if (pulses == 2) second_e = k;
            end
        end
        chk("hold_pulses", pulses, 2);
        chk("hold_first",  first_e, 5);
        chk("hold_second", second_e, 11);
        chk("hold_x1",     s(X_POST10), 2176);

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        set_in(2048, 0, 1024, 1024, 1024, 512, 512);
        start = 1'b1;
        @(negedge clk);                       // after E0
        start = 1'b0;
        @(negedge clk);                       // after E1
        @(negedge clk);                       // after E2: state GAIN, INNOV updated
        chk("midop_innov_pre", s(INNOV), -1024);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  int'(busy), 0);
        chk("midrst_done",  int'(done), 0);
        chk("midrst_innov", s(INNOV), 0);
        chk("midrst_x0",    s(X_POST00), 0);
        chk("midrst_x1",    s(X_POST10), 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pulses += int'(done);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pulses += int'(done) + int'(busy);
        end
        chk("midrst_quiet", pulses, 0);
        run_op("post_rst", 1024, 2048, 1024, 0, 1536, 512, 256, 512, 1280, 2176, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/posterior_state_serial.md
Name: posterior_state_serial

Overview:
- Kalman measurement-update (correction) step for a 2-state, 1-measurement filter. It is the counterpart of the serial prior-state (predict) block.
- Computes innovation y = z − H·x_prior, then X_POST = x_prior + K·y.
- Serial, resource-shared datapath: 2 fixed-point multipliers, 1 shared add/sub unit, small FSM. Consumes X_PRIOR00/X_PRIOR10 from the predict stage.

Parameters:
N, 20, data word width (signed two's complement)
FRAC, 10, fractional bits of every N-bit input/output (Q(N−FRAC).FRAC)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request pulse/level; sampled only in IDLE
xp00  in  N  prior state element 0
xp10  in  N  prior state element 1
h00  in  N  measurement row coefficient 0
h01  in  N  measurement row coefficient 1
z  in  N  scalar measurement
k00  in  N  Kalman gain element 0
k10  in  N  Kalman gain element 1
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse, results valid
X_POST00  out  N  posterior state element 0
X_POST10  out  N  posterior state element 1
INNOV  out  N  innovation y (N-bit, FRAC fractional bits)

Behaviour:
- Reset (async, rst_n=0): FSM→IDLE. done=0, busy=0, X_POST00=X_POST10=INNOV=0. All internal registers (operand latches, multiplier operands, intermediates) = 0.
- FSM states: IDLE → HX → INN → GAIN → UPD0 → UPD1 → IDLE.
- IDLE: start=1 at edge E0 does all of the following:
  - latches xp00, xp10, z, k00, k10 into internal registers; inputs may change afterwards without affecting the result;
  - loads the multipliers with h00·xp00 and h01·xp10;
  - busy←1, go to HX.
- HX (E1): hx(2N) ← p0 + p1 via the shared adder, truncated to 2N (wrap).
- INN (E2):
  - adder computes z_al − hx, where z_al = z sign-extended to 2N and shifted left FRAC;
  - y = sum[FRAC+N−1:FRAC] (floor truncation, wrap, no saturation);
  - INNOV ← y; internal y_reg ← y;
  - multiplier operands ← (k00, y) and (k10, y).
- GAIN (E3): g0 ← p0, g1 ← p1 (2N, 2·FRAC fractional bits).
- UPD0 (E4): X_POST00 ← ((xp00 sign-extended, <<FRAC) + g0)[FRAC+N−1:FRAC].
- UPD1 (E5): X_POST10 ← same form with xp10 and g1; done←1 for one cycle; busy←0; go to IDLE.
- Latency: done is high in the cycle following edge E5, i.e. 5 clocks after the start-sampling edge. Throughput is one update per 6 cycles, since back-to-back start is accepted in IDLE on the cycle done is high.
- Arithmetic:
  - the multiplier produces a full 2N signed product;
  - the adder is (2N+1)-bit full, used truncated to 2N;
  - all N-bit results take bits [FRAC+N−1:FRAC] (floor toward −∞, wrap on overflow).
- Only one add/sub unit exists. Subtraction is implemented as operand-B invert + carry-in, selected by state.
- start while busy: ignored, no queuing.
- Outputs hold their last values between operations. INNOV updates at E2, X_POST00 at E4, X_POST10 at E5. Consumers use the values only on done.
- rst_n asserted mid-operation: immediate return to IDLE, all outputs 0, no done pulse. The next start after release runs a full normal sequence.

Test Plan:
- Nominal (Q10): xp=(1024,2048), h=(1024,0), z=1536, k=(512,256), start 1 cycle → INNOV=512, X_POST00=1280, X_POST10=2176; done exactly 5 clocks after start edge, busy high 5 cycles.
- Negative innovation: xp=(2048,0), h=(1024,1024), z=1024, k=(512,512) → INNOV=−1024, X_POST00=1536, X_POST10=−512.
- Zero gain: k=(0,0), xp=(−300,700), h=(1024,1024), z=0 → X_POST00=−300, X_POST10=700, INNOV=−400.
- Floor truncation:
  - xp=(0,0), h=(1024,0), k=(512,512), z=1 → INNOV=1, X_POST00=X_POST10=0.
  - Same with z=−1 → INNOV=−1, X_POST00=X_POST10=−1.
- Handshake:
  - start held high for 10 cycles → exactly two done pulses, at E5 and E11;
  - inputs changed at E1 → results match values latched at E0;
  - second start pulse while busy → ignored.
- Reset mid-op: assert rst_n=0 in GAIN → outputs 0, busy 0, no done; release, run the nominal vector → nominal results.
